// File: rtl/dcache_controller_if.sv
// Pipeline-side and memory-side signals of the L1 data cache, bundled for port connection.
// The slave modport is the cache's view; master is the pipeline/memory environment.
interface dcache_controller_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);
  logic              p1_req_i;
  logic              p1_write_i;
  logic [ADDR_W-1:0] p1_addr_i;
  logic [31:0]       p1_data_i;
  logic [31:0]       p1_data_o;
  logic              p1_stall_o;
  logic              mem_enable_o;
  logic              mem_write_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [LINE_W-1:0] mem_data_o;
  logic [LINE_W-1:0] mem_data_i;
  logic              mem_ack_i;

  modport slave (
    input  p1_req_i, p1_write_i, p1_addr_i, p1_data_i,
    output p1_data_o, p1_stall_o,
    output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
    input  mem_data_i, mem_ack_i
  );

  modport master (
    output p1_req_i, p1_write_i, p1_addr_i, p1_data_i,
    input  p1_data_o, p1_stall_o,
    input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
    output mem_data_i, mem_ack_i
  );
endinterface

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate L1 data cache. Hits finish in the
// request cycle; misses stall the pipeline through write-back and refill.
module dcache_controller #(
  parameter int LINES  = 32,
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input logic                clk_i,
  input logic                rst_i,
  dcache_controller_if.slave bus
);
  localparam int IDX_W  = $clog2(LINES);
  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
  localparam int WORDS  = LINE_W / 32;
  localparam int WSEL_W = $clog2(WORDS);

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, REFILL_DONE} state_t;

  state_t state_q, state_d;

  logic [LINES-1:0]            valid_q;
  logic [LINES-1:0]            dirty_q;
  logic [TAG_W-1:0]            tag_q  [LINES];
  logic [WORDS-1:0][31:0]      data_q [LINES];

  logic                        mem_enable_q;
  logic                        mem_write_q;
  logic [ADDR_W-1:0]           mem_addr_q;
  logic [LINE_W-1:0]           mem_data_q;

  logic [IDX_W-1:0]            idx;
  logic [TAG_W-1:0]            req_tag;
  logic [WSEL_W-1:0]           wsel;
  logic [WORDS-1:0][31:0]      cur_words;
  logic                        hit;
  logic                        victim_dirty;
  logic                        store_hit;
  logic                        refill;
  logic                        unused_addr;

  assign idx          = bus.p1_addr_i[OFF_W +: IDX_W];
  assign req_tag      = bus.p1_addr_i[ADDR_W-1 -: TAG_W];
  assign wsel         = bus.p1_addr_i[2 +: WSEL_W];
  assign unused_addr  = ^bus.p1_addr_i[1:0];
  assign cur_words    = data_q[idx];
  assign hit          = bus.p1_req_i & valid_q[idx] & (tag_q[idx] == req_tag);
  assign victim_dirty = valid_q[idx] & dirty_q[idx];
  assign store_hit    = (state_q == IDLE) & hit & bus.p1_write_i;
  assign refill       = (state_q == ALLOCATE) & bus.mem_ack_i;

  always_comb begin
    state_d        = state_q;
    bus.p1_stall_o = bus.p1_req_i & ((state_q != IDLE) | ~hit);
    bus.p1_data_o  = '0;
    case (state_q)
      IDLE: begin
        if (hit && !bus.p1_write_i) begin
          bus.p1_data_o = cur_words[wsel];
        end
        if (bus.p1_req_i && !hit) begin
          state_d = victim_dirty ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK:   if (bus.mem_ack_i) state_d = ALLOCATE;
      ALLOCATE:    if (bus.mem_ack_i) state_d = REFILL_DONE;
      REFILL_DONE: state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  // Memory-side outputs are registered on the edge that enters each state,
  // so they are stable for the whole request.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      dirty_q      <= '0;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (bus.p1_req_i && !hit) begin
            mem_enable_q <= 1'b1;
            if (victim_dirty) begin
              mem_write_q <= 1'b1;
              mem_addr_q  <= {tag_q[idx], idx, {OFF_W{1'b0}}};
              mem_data_q  <= data_q[idx];
            end else begin
              mem_write_q <= 1'b0;
              mem_addr_q  <= {req_tag, idx, {OFF_W{1'b0}}};
            end
          end else if (store_hit) begin
            dirty_q[idx] <= 1'b1;
          end
        end
        WRITEBACK: begin
          if (bus.mem_ack_i) begin
            mem_write_q <= 1'b0;
            mem_addr_q  <= {req_tag, idx, {OFF_W{1'b0}}};
          end
        end
        ALLOCATE: begin
          if (bus.mem_ack_i) begin
            mem_enable_q <= 1'b0;
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Tag and data arrays need no reset: valid_q gates every use of them.
  always_ff @(posedge clk_i) begin
    if (refill) begin
      data_q[idx] <= bus.mem_data_i;
      tag_q[idx]  <= req_tag;
    end else if (store_hit) begin
      data_q[idx][wsel] <= bus.p1_data_i;
    end
  end

  assign bus.mem_enable_o = mem_enable_q;
  assign bus.mem_write_o  = mem_write_q;
  assign bus.mem_addr_o   = mem_addr_q;
  assign bus.mem_data_o   = mem_data_q;
endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: directed vector table, reset/ack corner sequences,
// and random accesses against a flat-memory reference with a line-residency model.
module tb_dcache_controller;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;
  localparam int LINES  = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dcache_controller_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

  dcache_controller #(.LINES(LINES), .LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- backing memory ----------------
  logic [255:0] mem_lines [logic [31:0]];

  function automatic logic [255:0] line_init(input logic [31:0] la);
    logic [255:0] l;
    for (int unsigned w = 0; w < 8; w++)
      l[w*32 +: 32] = (la * 32'h9E37_79B9) ^ (w * 32'h0101_0101) ^ 32'hA5A5_0000;
    return l;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0]  la;
    logic [255:0] l;
    la = {a[31:5], 5'b0};
    l  = mem_lines.exists(la) ? mem_lines[la] : line_init(la);
    return l[a[4:2]*32 +: 32];
  endfunction

  bit           auto_mem    = 1'b1;
  int           manual_req  = 0;
  int           manual_done = 0;
  int           n_rd = 0, n_wr = 0, busy = 0, misaligned = 0;
  logic [31:0]  last_rd_addr = '0, last_wb_addr = '0;
  logic [255:0] last_wb_data = '0;

  // Memory responder: random 0..3 extra cycles before the ack pulse.
  initial begin
    int wait_cnt;
    logic [31:0] la;
    wait_cnt       = -1;
    bus.mem_ack_i  = 1'b0;
    bus.mem_data_i = '0;
    forever begin
      @(posedge clk); #1;
      bus.mem_ack_i = 1'b0;
      if (manual_done != manual_req) begin
        manual_done++;
        bus.mem_ack_i  = 1'b1;
        bus.mem_data_i = {8{32'hBAD0_0BAD}};
      end else if (!auto_mem || rst || !bus.mem_enable_o) begin
        wait_cnt = -1;
      end else begin
        busy++;
        if (wait_cnt < 0) wait_cnt = $urandom_range(0, 3);
        if (wait_cnt == 0) begin
          la = bus.mem_addr_o;
          if (la[4:0] != 5'd0) misaligned++;
          if (bus.mem_write_o) begin
            mem_lines[la] = bus.mem_data_o;
            n_wr++;
            last_wb_addr = la;
            last_wb_data = bus.mem_data_o;
          end else begin
            bus.mem_data_i = mem_lines.exists(la) ? mem_lines[la] : line_init(la);
            n_rd++;
            last_rd_addr = la;
          end
          bus.mem_ack_i = 1'b1;
          wait_cnt = -1;
        end else begin
          wait_cnt--;
        end
      end
    end
  end

  // One pipeline access; returns load data, stall cycles and memory activity.
  task automatic txn(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                     output logic [31:0] rd, output int stall_n,
                     output int drd, output int dwr, output int dbusy);
    int r0, w0, b0;
    r0 = n_rd; w0 = n_wr; b0 = busy;
    @(negedge clk);
    bus.p1_req_i   = 1'b1;
    bus.p1_write_i = wr;
    bus.p1_addr_i  = a;
    bus.p1_data_i  = wd;
    #1;
    stall_n = 0;
    while (bus.p1_stall_o && stall_n <= 200) begin
      stall_n++;
      @(negedge clk); #1;
    end
    if (stall_n > 200) check("stall_timeout", 1, 0);
    rd = bus.p1_data_o;
    @(posedge clk); #1;
    bus.p1_req_i   = 1'b0;
    bus.p1_write_i = 1'b0;
    drd   = n_rd - r0;
    dwr   = n_wr - w0;
    dbusy = busy - b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_enable"}, bus.mem_enable_o, 0);
    check({tag, "_mem_write"},  bus.mem_write_o, 0);
    check({tag, "_mem_addr"},   bus.mem_addr_o, 0);
    check({tag, "_mem_data"},   bus.mem_data_o, 0);
    check({tag, "_p1_data"},    bus.p1_data_o, 0);
    check({tag, "_p1_stall"},   bus.p1_stall_o, 0);
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    int          exp_nrd;
    int          exp_nwr;
    logic [31:0] exp_rd_addr;
    logic [31:0] exp_wb_addr;
    logic [31:0] exp_wb_w1;
  } vec_t;

  vec_t         vecs [5];
  logic [255:0] tmp;
  logic [31:0]  rd;
  int           stall_n, drd, dwr, dbusy, n;

  int           res_tag   [LINES];
  bit           res_dirty [LINES];
  logic [31:0]  ref_mem   [logic [31:0]];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.p1_req_i   = 1'b0;
    bus.p1_write_i = 1'b0;
    bus.p1_addr_i  = '0;
    bus.p1_data_i  = '0;

    tmp = line_init(32'h40);  tmp[31:0] = 32'h1111_1111; mem_lines[32'h40]  = tmp;
    tmp = line_init(32'h440); tmp[31:0] = 32'h2222_2222; mem_lines[32'h440] = tmp;
    tmp = line_init(32'h840); tmp[31:0] = 32'h3333_3333; mem_lines[32'h840] = tmp;

    //          wr  addr    wdata         exp_rd        nrd nwr rd_addr wb_addr  wb_w1
    vecs[0] = '{0, 32'h40,  32'h0,        32'h1111_1111, 1, 0, 32'h40,  32'h0,  32'h0};
    vecs[1] = '{1, 32'h44,  32'hDEAD_BEEF, 32'h0,        0, 0, 32'h0,   32'h0,  32'h0};
    vecs[2] = '{0, 32'h44,  32'h0,        32'hDEAD_BEEF, 0, 0, 32'h0,   32'h0,  32'h0};
    vecs[3] = '{0, 32'h440, 32'h0,        32'h2222_2222, 1, 1, 32'h440, 32'h40, 32'hDEAD_BEEF};
    vecs[4] = '{0, 32'h840, 32'h0,        32'h3333_3333, 1, 0, 32'h840, 32'h0,  32'h0};

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    for (int unsigned i = 0; i < 5; i++) begin
      txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, stall_n, drd, dwr, dbusy);
      if (!vecs[i].wr) check($sformatf("vec%0d_data", i), rd, vecs[i].exp_rd);
      if (vecs[i].exp_nrd + vecs[i].exp_nwr == 0) check($sformatf("vec%0d_stall", i), stall_n, 0);
      else check($sformatf("vec%0d_stall", i), stall_n, dbusy + 2);
      check($sformatf("vec%0d_reads", i), drd, vecs[i].exp_nrd);
      check($sformatf("vec%0d_writes", i), dwr, vecs[i].exp_nwr);
      if (vecs[i].exp_nrd != 0) check($sformatf("vec%0d_rd_addr", i), last_rd_addr, vecs[i].exp_rd_addr);
      if (vecs[i].exp_nwr != 0) begin
        check($sformatf("vec%0d_wb_addr", i), last_wb_addr, vecs[i].exp_wb_addr);
        check($sformatf("vec%0d_wb_word1", i), last_wb_data[63:32], vecs[i].exp_wb_w1);
        check($sformatf("vec%0d_wb_word0", i), last_wb_data[31:0], 32'h1111_1111);
      end
    end

    // Reset while a refill is outstanding; the late ack must be ignored.
    auto_mem = 1'b0;
    @(negedge clk);
    bus.p1_req_i   = 1'b1;
    bus.p1_write_i = 1'b0;
    bus.p1_addr_i  = 32'h1040;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.mem_enable_o && n < 10);
    check("t5_enable", bus.mem_enable_o, 1);
    check("t5_write", bus.mem_write_o, 0);
    check("t5_addr", bus.mem_addr_o, 32'h1040);
    check("t5_stall", bus.p1_stall_o, 1);
    rst = 1'b1;
    bus.p1_req_i = 1'b0;
    @(negedge clk);
    check_reset_outputs("t5_rst");
    rst = 1'b0;
    manual_req++;
    repeat (3) @(negedge clk);
    check("t5_late_ack_enable", bus.mem_enable_o, 0);
    check("t5_late_ack_stall", bus.p1_stall_o, 0);
    auto_mem = 1'b1;
    txn(0, 32'h440, 32'h0, rd, stall_n, drd, dwr, dbusy);
    check("t5_old_line_reads", drd, 1);
    check("t5_old_line_data", rd, 32'h2222_2222);
    txn(0, 32'h1040, 32'h0, rd, stall_n, drd, dwr, dbusy);
    check("t5_reads", drd, 1);
    check("t5_writes", dwr, 0);
    check("t5_stall_cycles", stall_n, dbusy + 2);
    check("t5_data", rd, mem_word(32'h1040));

    // Idle pipeline with stray ack pulses.
    for (int unsigned c = 0; c < 20; c++) begin
      if ($urandom_range(0, 1) == 1) manual_req++;
      @(negedge clk);
      check("t6_stall", bus.p1_stall_o, 0);
      check("t6_enable", bus.mem_enable_o, 0);
    end
    txn(0, 32'h1040, 32'h0, rd, stall_n, drd, dwr, dbusy);
    check("t6_hit_stall", stall_n, 0);
    check("t6_hit_reads", drd, 0);
    check("t6_hit_data", rd, mem_word(32'h1040));

    // Random phase: fresh reset (all lines are clean here, so nothing is lost).
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("rand_rst");
    rst = 1'b0;
    for (int unsigned i = 0; i < LINES; i++) begin
      res_tag[i]   = -1;
      res_dirty[i] = 1'b0;
    end
    for (int unsigned it = 0; it < 300; it++) begin
      int unsigned tg, ix, w;
      bit          wr, hit, wb;
      logic [31:0] a, wa, wd, exp_d;
      tg = $urandom_range(0, 3);
      ix = $urandom_range(0, 3);
      w  = $urandom_range(0, 7);
      a  = (tg << 10) | (ix << 5) | (w << 2) | $urandom_range(0, 3);
      wa = {a[31:2], 2'b00};
      wr = 1'($urandom_range(0, 1));
      wd = $urandom;
      hit   = (res_tag[ix] == int'(tg));
      wb    = !hit && res_tag[ix] >= 0 && res_dirty[ix];
      exp_d = ref_mem.exists(wa) ? ref_mem[wa] : mem_word(wa);
      txn(wr, a, wd, rd, stall_n, drd, dwr, dbusy);
      if (!wr) check("rand_data", rd, exp_d);
      check("rand_stall", stall_n, hit ? 0 : dbusy + 2);
      check("rand_reads", drd, hit ? 0 : 1);
      check("rand_writes", dwr, wb ? 1 : 0);
      if (!hit) check("rand_rd_addr", last_rd_addr, {a[31:5], 5'b0});
      if (wb) check("rand_wb_addr", last_wb_addr, (res_tag[ix] << 10) | (ix << 5));
      if (!hit) res_dirty[ix] = 1'b0;
      res_tag[ix] = int'(tg);
      if (wr) begin
        res_dirty[ix] = 1'b1;
        ref_mem[wa]   = wd;
      end
    end
    check("addr_aligned", misaligned, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
